// File: rtl/sub_3_2_bit_masked.sv
// Masked (a - b) mod 8 on Boolean shares, 4-stage pipeline with 1-cycle AND gadgets.
// Optional borrow-out share output enabled by defining SUB_BORROW_OUT_EN.

module hpc2_and #(
  parameter int d    = 2,
  parameter int NRND = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [d-1:0]    x,
  input  logic [d-1:0]    y,
  input  logic [NRND-1:0] r,
  output logic [d-1:0]    z
);
  logic [d-1:0][d-1:0] term_d, term_q;

  // cross terms x_i&y_j and x_j&y_i share the same refresh bit r_{min,max}
  always_comb begin
    term_d = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i < j)
          term_d[i][j] = (x[i] & y[j]) ^ r[i*d - i*(i+1)/2 + j-i-1];
        else if (j < i)
          term_d[i][j] = (x[i] & y[j]) ^ r[j*d - j*(j+1)/2 + i-j-1];
        else
          term_d[i][j] = x[i] & y[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) term_q <= '0;
    else        term_q <= term_d;
  end

  always_comb begin
    z = '0;
    for (int i = 0; i < d; i++) z[i] = ^term_q[i];
  end
endmodule

module sub_3_2_bit_masked #(
  parameter  int d    = 2,
  localparam int NRND = d*(d-1)/2,
`ifdef SUB_BORROW_OUT_EN
  localparam int NR   = 5,
`else
  localparam int NR   = 4,
`endif
  localparam int LAT  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [3*d-1:0]     a_input,
  input  logic [2*d-1:0]     b_input,
  input  logic [NR*NRND-1:0] rnd,
  output logic               out_valid,
  output logic [3*d-1:0]     out_c
`ifdef SUB_BORROW_OUT_EN
  ,
  output logic [d-1:0]       out_borrow
`endif
);
  localparam logic [d-1:0] INV = {{(d-1){1'b0}}, 1'b1};

  logic [d-1:0] a0, a1, a2, b0, b1;
  logic [d-1:0] br0, t1, t2, nor_z, br1;
  logic [d-1:0] s0_q1, p1_q1, a2_q1;
  logic [d-1:0] s0_q2, s1_q2, a2_q2, t1_q2;
  logic [d-1:0] s0_q3, s1_q3, a2_q3;
  logic [LAT-1:0] valid_q;

  assign a0 = a_input[0 +: d];
  assign a1 = a_input[d +: d];
  assign a2 = a_input[2*d +: d];
  assign b0 = b_input[0 +: d];
  assign b1 = b_input[d +: d];

  hpc2_and #(.d(d), .NRND(NRND)) u_g0 (.clk(clk), .rst_n(rst_n), .x(a0 ^ INV), .y(b0),
    .r(rnd[0*NRND +: NRND]), .z(br0));
  hpc2_and #(.d(d), .NRND(NRND)) u_g1 (.clk(clk), .rst_n(rst_n), .x(a1 ^ INV), .y(b1),
    .r(rnd[1*NRND +: NRND]), .z(t1));
  hpc2_and #(.d(d), .NRND(NRND)) u_g2 (.clk(clk), .rst_n(rst_n), .x(p1_q1 ^ INV), .y(br0),
    .r(rnd[2*NRND +: NRND]), .z(t2));
  // OR via De Morgan: br1 = ~(~t1 & ~t2)
  hpc2_and #(.d(d), .NRND(NRND)) u_g3 (.clk(clk), .rst_n(rst_n), .x(t1_q2 ^ INV), .y(t2 ^ INV),
    .r(rnd[3*NRND +: NRND]), .z(nor_z));
  assign br1 = nor_z ^ INV;

`ifdef SUB_BORROW_OUT_EN
  hpc2_and #(.d(d), .NRND(NRND)) u_g4 (.clk(clk), .rst_n(rst_n), .x(a2_q3 ^ INV), .y(br1),
    .r(rnd[4*NRND +: NRND]), .z(out_borrow));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q1   <= '0;
      p1_q1   <= '0;
      a2_q1   <= '0;
      s0_q2   <= '0;
      s1_q2   <= '0;
      a2_q2   <= '0;
      t1_q2   <= '0;
      s0_q3   <= '0;
      s1_q3   <= '0;
      a2_q3   <= '0;
      out_c   <= '0;
      valid_q <= '0;
    end else begin
      s0_q1   <= a0 ^ b0;
      p1_q1   <= a1 ^ b1;
      a2_q1   <= a2;
      s0_q2   <= s0_q1;
      s1_q2   <= p1_q1 ^ br0;
      a2_q2   <= a2_q1;
      t1_q2   <= t1;
      s0_q3   <= s0_q2;
      s1_q3   <= s1_q2;
      a2_q3   <= a2_q2;
      out_c   <= {a2_q3 ^ br1, s1_q3, s0_q3};
      valid_q <= {valid_q[LAT-2:0], in_valid};
    end
  end

  assign out_valid = valid_q[LAT-1];
endmodule

// File: tb/tb_sub_3_2_bit_masked.sv
// Randomized bench for sub_3_2_bit_masked (d=2) against an arithmetic (a-b) mod 8 model.
module tb_sub_3_2_bit_masked;
  localparam int LAT = 4;
`ifdef SUB_BORROW_OUT_EN
  localparam int RW = 5;
`else
  localparam int RW = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [5:0]    a_input = '0;
  logic [3:0]    b_input = '0;
  logic [RW-1:0] rnd = '0;
  logic          out_valid;
  logic [5:0]    out_c;
`ifdef SUB_BORROW_OUT_EN
  logic [1:0]    out_borrow;
`endif

  sub_3_2_bit_masked #(.d(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_input(a_input), .b_input(b_input),
    .rnd(rnd), .out_valid(out_valid), .out_c(out_c)
`ifdef SUB_BORROW_OUT_EN
    , .out_borrow(out_borrow)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; int c; int br; int due;} exp_t;
  exp_t q[$];
  exp_t m;
  int total = 0, bad = 0, next_id = 0, id0 = 0;
  int res_log[1024];
  logic [5:0] raw_log[1024];

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unmask3(input logic [5:0] v);
    int r = 0;
    for (int i = 0; i < 3; i++) if (v[2*i] ^ v[2*i+1]) r += (1 << i);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check_val("rst_valid", int'(out_valid), 0);
      check_val("rst_c", int'(out_c), 0);
`ifdef SUB_BORROW_OUT_EN
      check_val("rst_borrow", int'(out_borrow), 0);
`endif
    end else if (out_valid) begin
      if (q.size() == 0) check_val("spurious_valid", 1, 0);
      else begin
        m = q.pop_front();
        check_val("diff", unmask3(out_c), m.c);
        check_val("latency", cyc, m.due);
`ifdef SUB_BORROW_OUT_EN
        check_val("borrow", int'(out_borrow[0] ^ out_borrow[1]), m.br);
`endif
        res_log[m.id] = unmask3(out_c);
        raw_log[m.id] = out_c;
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      m = q.pop_front();
      check_val("missing_valid", 0, 1);
    end
  end

  // am/bm are the share-1 values per bit; share 0 carries value ^ mask
  task automatic drive(input bit v, input int a, input int b, input bit zr,
                       input int am, input int bm);
    logic [5:0]  av;
    logic [3:0]  bv;
    logic [31:0] rr;
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      av[2*i+1] = am[i];
      av[2*i]   = a[i] ^ am[i];
    end
    for (int i = 0; i < 2; i++) begin
      bv[2*i+1] = bm[i];
      bv[2*i]   = b[i] ^ bm[i];
    end
    rr = $urandom;
    a_input  = av;
    b_input  = bv;
    in_valid = v;
    rnd      = zr ? '0 : rr[RW-1:0];
    if (v) begin
      e.id  = next_id;
      e.c   = (a - b + 8) % 8;
      e.br  = (a < b) ? 1 : 0;
      e.due = cyc + LAT;
      q.push_back(e);
      next_id++;
    end
  endtask

  task automatic idle();
    drive(0, $urandom_range(0, 7), $urandom_range(0, 3), 0, $urandom, $urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    drive(1, 5, 3, 0, $urandom, $urandom);
    drive(1, 1, 2, 0, $urandom, $urandom);
    drive(1, 0, 3, 0, $urandom, $urandom);
    drive(1, 7, 0, 0, $urandom, $urandom);

    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 4; b++)
        drive(1, a, b, 0, $urandom, $urandom);
    idle();
    idle();

    id0 = next_id;
    drive(1, 6, 1, 1, 0, 0);
    drive(1, 6, 1, 0, $urandom, $urandom);
    drive(1, 6, 1, 1, 1, 0);
    idle();

    drive(1, $urandom_range(0, 7), $urandom_range(0, 3), 0, $urandom, $urandom);
    idle();
    drive(1, $urandom_range(0, 7), $urandom_range(0, 3), 0, $urandom, $urandom);
    idle();
    repeat (LAT + 2) idle();

    drive(1, 4, 1, 0, $urandom, $urandom);
    drive(1, 2, 3, 0, $urandom, $urandom);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    idle();
    drive(1, 3, 1, 0, $urandom, $urandom);
    repeat (LAT + 2) idle();

    repeat (200)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7) == 0, $urandom, $urandom);
    idle();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    check_val("drain_empty", q.size(), 0);

    check_val("rnd_indep", res_log[id0+1], res_log[id0]);
    check_val("split_indep", res_log[id0+2], res_log[id0]);
    check_val("split_shares_differ", (raw_log[id0+2] != raw_log[id0]) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
